// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned calc_digits(input int unsigned width,
                                              input int unsigned digit_w);
    return width / digit_w;
  endfunction

  // Digit counter needs at least one bit even when a single digit covers the word.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_adder_digit.sv
// DIGIT_W-bit ripple-carry slice; also exposes the carry into its top bit
// so the parent can derive signed overflow on the most significant digit.
module adder_digit #(
  parameter int unsigned DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout,
  output logic               c_msb_in
);

  always_comb begin : ripple
    logic c;
    s        = '0;
    c        = cin;
    c_msb_in = 1'b0;
    for (int i = 0; i < int'(DIGIT_W); i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      if (i == int'(DIGIT_W) - 1) c_msb_in = c;
      c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT_W slice reused over WIDTH/DIGIT_W cycles, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DIGIT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N     = calc_digits(WIDTH, DIGIT_W);
  localparam int unsigned CNT_W = cnt_width(N);

  if (WIDTH < 1 || DIGIT_W < 1 || (WIDTH % DIGIT_W) != 0) begin : g_bad_cfg
    $error("serial_adder: WIDTH must be >= 1 and a multiple of DIGIT_W");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic               carry_q, carry_d, cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT_W-1:0] dig_s;
  logic               dig_co, dig_cm;
  logic               last_digit;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  assign last_digit = (cnt_q == CNT_W'(N - 1));

  adder_digit #(.DIGIT_W(DIGIT_W)) u_digit (
    .a        (a_q[DIGIT_W-1:0]),
    .b        (b_q[DIGIT_W-1:0]),
    .cin      (carry_q),
`ifdef SERIAL_ADDER_OVF_EN
    .c_msb_in (dig_cm),
`else
    .c_msb_in (),
`endif
    .s        (dig_s),
    .cout     (dig_co)
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign dig_cm = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = BUSY;
      BUSY:    if (last_digit) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Subtraction is A + ~B + ~borrow, so B is inverted and the carry seeded at accept.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        a_d     = a_q >> DIGIT_W;
        b_d     = b_q >> DIGIT_W;
        res_d   = (res_q >> DIGIT_W) | (WIDTH'(dig_s) << (WIDTH - DIGIT_W));
        carry_d = dig_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_digit) begin
          sum_d  = res_d;
          cout_d = dig_co;
`ifdef SERIAL_ADDER_OVF_EN
          ovf_d  = dig_cm ^ dig_co;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
